// File: rtl/pipe_core.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_core
//  Purpose  : In-order four-stage (ID, EX, MM, WB) integer pipeline fed by a
//             valid/ready instruction port. Parametrised data width and
//             register count. Detects RAW hazards and stalls on them. Keeps
//             counters for retired instructions and stall cycles.
//  Option   : PIPE_CORE_FORWARD_EN - EX-stage forwarding from MM/WB. With it
//             defined the pipeline never stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_core #(
    parameter int DW   = 8,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [31:0]             instr,
    output logic                    instr_ready,
    output logic                    wb_we,
    output logic [$clog2(NREG)-1:0] wb_rd,
    output logic [DW-1:0]           wb_data,
    output logic [15:0]             retired_cnt,
    output logic [15:0]             stall_cnt
);
    localparam int AW = $clog2(NREG);

    localparam logic [2:0] C_ALU_ADD = 3'd0;
    localparam logic [2:0] C_ALU_SUB = 3'd1;
    localparam logic [2:0] C_ALU_AND = 3'd2;
    localparam logic [2:0] C_ALU_OR  = 3'd3;
    localparam logic [2:0] C_ALU_XOR = 3'd4;
    localparam logic [2:0] C_ALU_SLT = 3'd5;

    // Pipeline state
    logic          id_valid_q;
    logic [31:0]   id_instr_q;
    logic          ex_valid_q, ex_we_q;
    logic [AW-1:0] ex_rd_q;
    logic [2:0]    ex_alu_q;
    logic [DW-1:0] ex_a_q, ex_b_q;
    logic          mm_valid_q, mm_we_q;
    logic [AW-1:0] mm_rd_q;
    logic [DW-1:0] mm_res_q;
    logic          wb_valid_q, wb_we_q;
    logic [AW-1:0] wb_rd_q;
    logic [DW-1:0] wb_data_q;
    logic [15:0]   retired_q, stall_q;
    logic [DW-1:0] rf_q [NREG];

    // Decode fields
    logic [5:0]    w_op, w_funct;
    logic [AW-1:0] w_rs, w_rt, w_rdf, w_dest;
    logic [31:0]   w_imm32;
    logic          w_dec_we, w_use_rs, w_use_rt, w_is_imm;
    logic [2:0]    w_alu;
    logic [DW-1:0] w_rs_val, w_rt_val;
    logic          w_hazard, w_accept;
    logic [DW-1:0] w_ex_a, w_ex_b, w_ex_res;
    logic          w_unused;

    assign w_op    = id_instr_q[31:26];
    assign w_funct = id_instr_q[5:0];
    assign w_rs    = id_instr_q[21 +: AW];
    assign w_rt    = id_instr_q[16 +: AW];
    assign w_rdf   = id_instr_q[11 +: AW];
    assign w_imm32 = {{16{id_instr_q[15]}}, id_instr_q[15:0]};
    assign w_unused = ^{id_instr_q, w_imm32};

    // Instruction decode; unknown opcodes/functs become NOPs with we=0
    always_comb begin
        w_dec_we = 1'b0;
        w_dest   = w_rdf;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_is_imm = 1'b0;
        w_alu    = C_ALU_ADD;
        if (w_op == 6'b000000) begin
            w_dec_we = 1'b1;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
            case (w_funct)
                6'b100000: w_alu = C_ALU_ADD;
                6'b100010: w_alu = C_ALU_SUB;
                6'b100100: w_alu = C_ALU_AND;
                6'b100101: w_alu = C_ALU_OR;
                6'b100110: w_alu = C_ALU_XOR;
                6'b101010: w_alu = C_ALU_SLT;
                default: begin
                    w_dec_we = 1'b0;
                    w_use_rs = 1'b0;
                    w_use_rt = 1'b0;
                end
            endcase
        end else if (w_op == 6'b001000) begin
            w_dec_we = 1'b1;
            w_dest   = w_rt;
            w_use_rs = 1'b1;
            w_is_imm = 1'b1;
        end
        // r0 is hard-wired, so writes to it are dropped right here
        if (w_dest == '0) w_dec_we = 1'b0;
    end

    // Register read with write-through from the WB stage
    always_comb begin
        w_rs_val = rf_q[w_rs];
        w_rt_val = rf_q[w_rt];
        if (wb_we_q && wb_rd_q == w_rs) w_rs_val = wb_data_q;
        if (wb_we_q && wb_rd_q == w_rt) w_rt_val = wb_data_q;
        if (w_rs == '0) w_rs_val = '0;
        if (w_rt == '0) w_rt_val = '0;
    end

`ifdef PIPE_CORE_FORWARD_EN
    logic [AW-1:0] ex_rs_q, ex_rt_q;

    assign w_hazard = 1'b0;

    // Operand forwarding into EX: MM result wins over WB result
    always_comb begin
        w_ex_a = ex_a_q;
        w_ex_b = ex_b_q;
        if (ex_rs_q != '0) begin
            if (mm_we_q && mm_rd_q == ex_rs_q)      w_ex_a = mm_res_q;
            else if (wb_we_q && wb_rd_q == ex_rs_q) w_ex_a = wb_data_q;
        end
        if (ex_rt_q != '0) begin
            if (mm_we_q && mm_rd_q == ex_rt_q)      w_ex_b = mm_res_q;
            else if (wb_we_q && wb_rd_q == ex_rt_q) w_ex_b = wb_data_q;
        end
    end

    // Source indices carried into EX; zero when the operand is not a register
    always_ff @(posedge clk) begin
        if (rst || w_hazard) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= w_use_rs ? w_rs : '0;
            ex_rt_q <= w_use_rt ? w_rt : '0;
        end
    end
`else
    logic w_hz_rs, w_hz_rt;

    // A producer still in EX or MM is not yet visible to the ID read
    assign w_hz_rs  = w_use_rs && (w_rs != '0) &&
                      ((ex_we_q && ex_rd_q == w_rs) || (mm_we_q && mm_rd_q == w_rs));
    assign w_hz_rt  = w_use_rt && (w_rt != '0) &&
                      ((ex_we_q && ex_rd_q == w_rt) || (mm_we_q && mm_rd_q == w_rt));
    assign w_hazard = id_valid_q && (w_hz_rs || w_hz_rt);
    assign w_ex_a   = ex_a_q;
    assign w_ex_b   = ex_b_q;
`endif

    assign instr_ready = ~rst & (~id_valid_q | ~w_hazard);
    assign w_accept    = instr_valid & instr_ready;

    // EX-stage ALU, all results wrap at DW bits
    always_comb begin
        w_ex_res = '0;
        case (ex_alu_q)
            C_ALU_ADD: w_ex_res = w_ex_a + w_ex_b;
            C_ALU_SUB: w_ex_res = w_ex_a - w_ex_b;
            C_ALU_AND: w_ex_res = w_ex_a & w_ex_b;
            C_ALU_OR:  w_ex_res = w_ex_a | w_ex_b;
            C_ALU_XOR: w_ex_res = w_ex_a ^ w_ex_b;
            C_ALU_SLT: w_ex_res = {{(DW-1){1'b0}}, ($signed(w_ex_a) < $signed(w_ex_b))};
            default:   w_ex_res = '0;
        endcase
    end

    // Pipeline advance: ID holds on hazard while a bubble enters EX
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            ex_valid_q <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_rd_q    <= '0;
            ex_alu_q   <= C_ALU_ADD;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            mm_valid_q <= 1'b0;
            mm_we_q    <= 1'b0;
            mm_rd_q    <= '0;
            mm_res_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            if (w_accept) begin
                id_valid_q <= 1'b1;
                id_instr_q <= instr;
            end else if (!w_hazard) begin
                id_valid_q <= 1'b0;
            end

            ex_valid_q <= id_valid_q & ~w_hazard;
            ex_we_q    <= id_valid_q & ~w_hazard & w_dec_we;
            ex_rd_q    <= w_dest;
            ex_alu_q   <= w_alu;
            ex_a_q     <= w_rs_val;
            ex_b_q     <= w_is_imm ? w_imm32[DW-1:0] : w_rt_val;

            mm_valid_q <= ex_valid_q;
            mm_we_q    <= ex_we_q;
            mm_rd_q    <= ex_rd_q;
            mm_res_q   <= w_ex_res;

            wb_valid_q <= mm_valid_q;
            wb_we_q    <= mm_we_q;
            wb_rd_q    <= mm_rd_q;
            wb_data_q  <= mm_res_q;
        end
    end

    // Register file: cleared on reset, written at the end of the WB cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we_q) begin
            rf_q[wb_rd_q] <= wb_data_q;
        end
    end

    // Performance counters, free-running and wrapping at 2^16
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (wb_valid_q) retired_q <= retired_q + 16'd1;
            if (w_hazard)   stall_q   <= stall_q + 16'd1;
        end
    end

    assign wb_we       = wb_we_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_core
//  Purpose  : Directed self-checking bench for pipe_core (DW=8, NREG=32).
//             Expectations follow PIPE_CORE_FORWARD_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_core;
    localparam int DW = 8;
    localparam int NREG = 32;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_OR = 6'b100101, F_SLT = 6'b101010;
    localparam logic [31:0] NOP_I = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [DW-1:0] wb_data;
    logic [15:0] retired_cnt, stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int q_rd[$];
    int q_data[$];
    int q_cyc[$];

    pipe_core #(.DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every register-file write seen on the WB port
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            q_rd.push_back(int'(wb_rd));
            q_data.push_back(int'(wb_data));
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_rd.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    // Offer one instruction; returns after the accepting edge with the
    // number of cycles instr_ready was low
    task automatic send(input logic [31:0] ins, output int waits);
        waits = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) check("send_timeout", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Read a register through "or r31, idx, r0" and compare
    task automatic read_reg(input logic [4:0] idx, input int exp, input string tag);
        int w;
        clear_log();
        send(rtype(idx, 5'd0, 5'd31, F_OR), w);
        idle(6);
        check({tag, "_n"}, q_data.size(), 1);
        if (q_data.size() == 1) check(tag, q_data[0], exp);
    endtask

    initial begin
        int w;
        int s0, r0;
        int exp_w1, exp_w2, exp_gap;
`ifdef PIPE_CORE_FORWARD_EN
        exp_w1 = 0; exp_w2 = 0; exp_gap = 1;
`else
        exp_w1 = 1; exp_w2 = 2; exp_gap = 3;
`endif
        // ---- reset held 2 cycles with instr_valid high
        rst = 1'b1;
        instr_valid = 1'b1;
        instr = addi(5'd1, 5'd0, 16'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, instr_ready}, 0);
        check("rst_wb_we", {31'd0, wb_we}, 0);
        check("rst_wb_data", {24'd0, wb_data}, 0);
        check("rst_retired", {16'd0, retired_cnt}, 0);
        check("rst_stall", {16'd0, stall_cnt}, 0);
        rst = 1'b0;
        instr_valid = 1'b0;

        // ---- single op: addi r1,r0,5, WB in cycle 4
        send(addi(5'd1, 5'd0, 16'd5), w);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("single_we", {31'd0, wb_we}, 1);
        check("single_rd", {27'd0, wb_rd}, 1);
        check("single_data", {24'd0, wb_data}, 32'h05);
        @(negedge clk);
        check("single_retired", {16'd0, retired_cnt}, 1);
        read_reg(5'd1, 5, "rd_r1");
        read_reg(5'd2, 0, "rd_r2_clear");

        // ---- back-to-back RAW
        clear_log();
        s0 = int'(stall_cnt);
        send(addi(5'd1, 5'd0, 16'd5), w);
        send(rtype(5'd1, 5'd1, 5'd2, F_ADD), w);
        send(addi(5'd7, 5'd0, 16'd1), w);
        check("raw1_waits", w, exp_w2);
        idle(8);
        check("raw1_stalls", int'(stall_cnt) - s0, exp_w2);
        check("raw1_n", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("raw1_rd", q_rd[1], 2);
            check("raw1_data", q_data[1], 32'h0A);
            check("raw1_gap", q_cyc[1] - q_cyc[0], exp_gap);
        end

        // ---- RAW at distance 2
        clear_log();
        s0 = int'(stall_cnt);
        send(addi(5'd3, 5'd0, 16'd3), w);
        send(addi(5'd9, 5'd0, 16'd0), w);
        send(rtype(5'd3, 5'd3, 5'd4, F_ADD), w);
        send(addi(5'd7, 5'd0, 16'd1), w);
        check("raw2_waits", w, exp_w1);
        idle(8);
        check("raw2_stalls", int'(stall_cnt) - s0, exp_w1);
        if (q_data.size() == 4) check("raw2_data", q_data[2], 6);
        else check("raw2_n", q_data.size(), 4);

        // ---- RAW at distance 3: no stall
        clear_log();
        s0 = int'(stall_cnt);
        send(addi(5'd5, 5'd0, 16'd7), w);
        send(NOP_I, w);
        send(NOP_I, w);
        send(rtype(5'd5, 5'd5, 5'd6, F_ADD), w);
        send(addi(5'd7, 5'd0, 16'd1), w);
        check("raw3_waits", w, 0);
        idle(8);
        check("raw3_stalls", int'(stall_cnt) - s0, 0);
        if (q_data.size() == 3) check("raw3_data", q_data[1], 14);
        else check("raw3_n", q_data.size(), 3);

        // ---- width / sign handling at DW=8
        clear_log();
        send(addi(5'd1, 5'd0, 16'hFFFF), w);
        send(rtype(5'd1, 5'd1, 5'd2, F_ADD), w);
        send(rtype(5'd1, 5'd0, 5'd3, F_SLT), w);
        send(rtype(5'd0, 5'd1, 5'd4, F_SUB), w);
        idle(8);
        check("ws_n", q_data.size(), 4);
        if (q_data.size() == 4) begin
            check("ws_addi", q_data[0], 32'hFF);
            check("ws_add", q_data[1], 32'hFE);
            check("ws_slt", q_data[2], 32'h01);
            check("ws_sub", q_data[3], 32'h01);
            check("ws_sub_rd", q_rd[3], 4);
        end

        // ---- r0 write and NOP: retire without writing
        clear_log();
        r0 = int'(retired_cnt);
        send(addi(5'd0, 5'd0, 16'd9), w);
        send(NOP_I, w);
        idle(6);
        check("r0nop_writes", q_data.size(), 0);
        check("r0nop_retired", int'(retired_cnt) - r0, 2);
        read_reg(5'd0, 0, "rd_r0");

        // ---- reset while the first of three is in MM
        clear_log();
        send(addi(5'd1, 5'd0, 16'd1), w);
        send(addi(5'd2, 5'd0, 16'd2), w);
        send(addi(5'd3, 5'd0, 16'd3), w);
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("mid_ready", {31'd0, instr_ready}, 0);
        check("mid_wb_we", {31'd0, wb_we}, 0);
        check("mid_retired", {16'd0, retired_cnt}, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_writes", q_data.size(), 0);
        read_reg(5'd1, 0, "mid_r1");
        read_reg(5'd2, 0, "mid_r2");
        read_reg(5'd3, 0, "mid_r3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_core.md
# pipe_core

Parametrised successor to the fixed 8-bit datapath: an in-order four-stage integer pipeline (ID, EX, MM, WB) with configurable data width and register count, RAW hazard detection with stall, optional EX-stage forwarding, and performance counters. Instructions arrive through a valid/ready handshake in place of an internal PC and instruction memory. This block drops into the datapath level below the fetch logic.

## Interface
- DW, 8: data and register width in bits (4..32)
- NREG, 32: register count, power of two, 2..32; AW = clog2(NREG)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instr is offered
- instr  in  32  MIPS-format instruction
- instr_ready  out  1  pipeline accepts instr this cycle
- wb_we  out  1  WB stage writes the register file this cycle
- wb_rd  out  AW  WB destination index
- wb_data  out  DW  WB result
- retired_cnt  out  16  instructions that have left WB
- stall_cnt  out  16  cycles in which a hazard stall was asserted

## Operation
- Acceptance: an instruction is accepted on the edge where instr_valid and instr_ready are both 1, and is loaded into the ID register.
- Decode: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], each truncated to its low AW bits.
- opcode 000000 (R-type), dest rd, uses rs and rt. funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 101010 slt. slt is a signed compare that returns 1 or 0.
- opcode 001000 (addi): dest rt, uses rs. Operand is instr[15:0] sign-extended or truncated to DW.
- Any other opcode or funct is a NOP. It travels down the pipe with we=0.
- Arithmetic wraps mod 2^DW.
- Register 0 reads as 0. Any write to it is suppressed: we is forced to 0 at decode.
- Register file: combinational read in ID, written at the edge that ends the WB cycle. A read in ID of a register being written by WB in the same cycle returns the WB data (write-through bypass).
- Hazard (ID valid):
  - A used source equals a nonzero dest with we=1 in EX or MM.
  - On hazard: ID holds, a bubble (valid=0) enters EX, instr_ready=0, and stall_cnt increments.
- instr_ready = ~rst & (~id_valid | ~hazard). It is combinational from pipeline state only and never depends on instr_valid.
- When ID is not stalled and no instruction is accepted, ID becomes empty (valid=0).
- retired_cnt increments for every valid instruction in WB, including NOPs. Both counters wrap at 2^16.
- Reset:
  - All stage valid bits, we bits and stage registers are cleared, and every register file entry is set to 0.
  - wb_we=0, wb_rd=0, wb_data=0, both counters 0, instr_ready=0 during the reset cycle.
  - Reset asserted mid-operation discards all in-flight instructions; none of them writes.

## Timing
- Instruction accepted at edge 0: ID in cycle 1, EX in cycle 2, MM in cycle 3, WB in cycle 4 (wb_* valid), register file updated at edge 4.
- Without forwarding:
  - A dependent instruction immediately following its producer stalls 2 cycles.
  - At distance 2 it stalls 1 cycle.
  - At distance 3 or more it does not stall.
- With forwarding, throughput is 1 instruction/cycle with no stalls.
- All outputs except instr_ready are registered.

## Configuration
- PIPE_CORE_FORWARD_EN defined:
  - EX operand muxes select the MM result (priority) or the WB result when that stage is valid, has we=1, and its dest equals the source register (nonzero).
  - The hazard term is constant 0, so stall_cnt stays 0.
- Undefined: no forwarding muxes; stall logic as specified above.

## Test plan
- Reset: hold rst 2 cycles with instr_valid=1 -> instr_ready=0, wb_we=0, wb_data=0, counters 0; afterwards all registers read 0.
- Single op: addi r1,r0,5 accepted at edge 0 -> cycle 4 wb_we=1, wb_rd=1, wb_data=0x05; retired_cnt=1 after edge 4.
- Back-to-back RAW: addi r1,r0,5 then add r2,r1,r1, instr_valid held:
  - Without the macro: instr_ready low 2 cycles, stall_cnt=2, r2 WB data 0x0A.
  - With the macro: no stall, r2 WB one cycle after r1.
- Width/sign (DW=8): addi r1,r0,0xFFFF -> 0xFF; add r2,r1,r1 -> 0xFE; slt r3,r1,r0 -> 0x01; sub r4,r0,r1 -> 0x01.
- r0 and NOP: addi r0,r0,9 and opcode 111111 -> wb_we=0 both; r0 still reads 0; retired_cnt +2.
- Mid-flight reset: issue 3 addi to r1..r3, assert rst when the first is in MM -> no wb_we pulse; r1..r3 read 0 after reset.
